// File: rtl/alu_bist_pkg.sv
// Shared types, edge-sweep constants and the ALU golden model for the ALU self-test controller.
package alu_bist_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'd0,
    OP_SUB   = 2'd1,
    OP_INV_A = 2'd2,
    OP_ROR_B = 2'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EDGE,
    ST_RAND,
    ST_DRAIN,
    ST_DONE
  } bist_state_e;

  localparam int NUM_EDGE_VEC = 36;
  localparam logic [3:0] EDGE_VALS [3] = '{4'b0000, 4'b1000, 4'b0111};

  // 5-bit signed result the ALU must produce for one vector
  function automatic logic [4:0] alu_golden(input logic [1:0] op, input logic [3:0] a,
                                            input logic [3:0] b);
    logic [4:0] sa;
    logic [4:0] sb;
    sa = {a[3], a};
    sb = {b[3], b};
    case (alu_op_e'(op))
      OP_ADD:   alu_golden = sa + sb;
      OP_SUB:   alu_golden = sa - sb;
      OP_INV_A: alu_golden = {1'b0, ~a};
      default:  alu_golden = {4'b0000, |b};
    endcase
  endfunction

endpackage

// File: rtl/alu_bist_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) with synchronous seed load and advance enable.
module alu_bist_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        adv,
  output logic [15:0] state
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= SEED;
    else if (load)
      state <= SEED;
    else if (adv)
      state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
  end

endmodule

// File: rtl/alu_bist_ctrl.sv
// Self-test initiator for the 4-bit ALU: edge sweep then LFSR vectors, compared ALU_LATENCY+1 edges later.
// Optional first-mismatch capture ports are built when BIST_FAIL_LOG_EN is defined.
module alu_bist_ctrl
  import alu_bist_pkg::*;
#(
  parameter int          NUM_RAND    = 50,
  parameter int          ALU_LATENCY = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [1:0]       alu_opcode,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic             alu_vld,
  input  logic [4:0]       alu_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef BIST_FAIL_LOG_EN
  ,
  output logic             fail_vld,
  output logic [1:0]       fail_opcode,
  output logic [3:0]       fail_a,
  output logic [3:0]       fail_b,
  output logic [4:0]       fail_got,
  output logic [4:0]       fail_exp
`endif
);

  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  bist_state_e      state;
  logic [5:0]       idx;
  logic [9:0]       rcnt;
  logic [ALU_LATENCY:0] pipe_vld;
  logic [4:0]       pipe_exp [ALU_LATENCY+1];

  logic             start_run, ld, use_rand, mismatch, pending;
  logic [5:0]       edge_idx;
  logic [1:0]       ai, bi;
  logic [1:0]       nxt_op;
  logic [3:0]       nxt_a, nxt_b;
  logic [ERR_W-1:0] err_nxt;
  logic [15:0]      lfsr_q;
  logic [5:0]       lfsr_unused;

  assign lfsr_unused = lfsr_q[15:10];

  alu_bist_lfsr16 #(.SEED(SEED_EFF)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (start_run),
    .adv   (use_rand),
    .state (lfsr_q)
  );

  // Next vector: edge index decomposes as opcode*9 + a_idx*3 + b_idx
  always_comb begin
    start_run = start && (state == ST_IDLE || state == ST_DONE);
    ld        = 1'b0;
    use_rand  = 1'b0;
    edge_idx  = '0;
    if (start_run) begin
      ld = 1'b1;
    end else if (state == ST_EDGE) begin
      ld = 1'b1;
      if (idx == 6'(NUM_EDGE_VEC - 1))
        use_rand = 1'b1;
      else
        edge_idx = idx + 6'd1;
    end else if (state == ST_RAND && rcnt != 10'(NUM_RAND - 1)) begin
      ld       = 1'b1;
      use_rand = 1'b1;
    end
    ai = 2'((edge_idx % 6'd9) / 6'd3);
    bi = 2'(edge_idx % 6'd3);
    if (use_rand) begin
      {nxt_a, nxt_b, nxt_op} = lfsr_q[9:0];
    end else begin
      nxt_op = 2'(edge_idx / 6'd9);
      nxt_a  = EDGE_VALS[ai];
      nxt_b  = EDGE_VALS[bi];
    end
  end

  // The compare at this edge also counts toward pass when the run finishes on it
  always_comb begin
    mismatch = pipe_vld[ALU_LATENCY] && (alu_c !== pipe_exp[ALU_LATENCY]);
    pending  = |pipe_vld[ALU_LATENCY-1:0];
    if (start_run)
      err_nxt = '0;
    else if (mismatch && err_count != '1)
      err_nxt = err_count + ERR_W'(1);
    else
      err_nxt = err_count;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      rcnt       <= '0;
      pipe_vld   <= '0;
      for (int k = 0; k <= ALU_LATENCY; k++) pipe_exp[k] <= '0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_vld    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
    end else begin
      pipe_vld    <= {pipe_vld[ALU_LATENCY-1:0], ld};
      pipe_exp[0] <= alu_golden(nxt_op, nxt_a, nxt_b);
      for (int k = 1; k <= ALU_LATENCY; k++) pipe_exp[k] <= pipe_exp[k-1];
      err_count <= err_nxt;
      if (ld) begin
        alu_opcode <= nxt_op;
        alu_a      <= nxt_a;
        alu_b      <= nxt_b;
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_EDGE;
            idx     <= '0;
            busy    <= 1'b1;
            alu_vld <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
          end
        end
        ST_EDGE: begin
          if (idx == 6'(NUM_EDGE_VEC - 1)) begin
            state <= ST_RAND;
            rcnt  <= '0;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        ST_RAND: begin
          if (rcnt == 10'(NUM_RAND - 1)) begin
            state   <= ST_DRAIN;
            alu_vld <= 1'b0;
          end else begin
            rcnt <= rcnt + 10'd1;
          end
        end
        ST_DRAIN: begin
          if (!pending) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BIST_FAIL_LOG_EN
  logic [9:0] pipe_vec [ALU_LATENCY+1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= ALU_LATENCY; k++) pipe_vec[k] <= '0;
      fail_vld    <= 1'b0;
      fail_opcode <= '0;
      fail_a      <= '0;
      fail_b      <= '0;
      fail_got    <= '0;
      fail_exp    <= '0;
    end else begin
      pipe_vec[0] <= {nxt_op, nxt_a, nxt_b};
      for (int k = 1; k <= ALU_LATENCY; k++) pipe_vec[k] <= pipe_vec[k-1];
      if (start_run) begin
        fail_vld    <= 1'b0;
        fail_opcode <= '0;
        fail_a      <= '0;
        fail_b      <= '0;
        fail_got    <= '0;
        fail_exp    <= '0;
      end else if (mismatch && !fail_vld) begin
        fail_vld                        <= 1'b1;
        {fail_opcode, fail_a, fail_b}   <= pipe_vec[ALU_LATENCY];
        fail_got                        <= alu_c;
        fail_exp                        <= pipe_exp[ALU_LATENCY];
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench: two controllers (ALU latency 1 and 3) share start/reset, each beside its own behavioural ALU.
module tb_alu_bist_ctrl;

  localparam int NR = 50;
  localparam int N  = 36 + NR;

  logic clk_tb = 1'b0;
  logic rst;
  logic start;
  logic fault;

  logic [1:0] op0, op1;
  logic [3:0] a0, b0, a1, b1;
  logic       vld0, vld1, busy0, busy1, done0, done1, pass0, pass1;
  logic [4:0] c0, c1, s1, s2;
  logic [7:0] err0, err1;
`ifdef BIST_FAIL_LOG_EN
  logic       fv0, fv1;
  logic [1:0] fop0, fop1;
  logic [3:0] fa0, fb0, fa1, fb1;
  logic [4:0] fg0, fe0, fg1, fe1;
`endif

  logic [1:0] vop [N];
  logic [3:0] va  [N];
  logic [3:0] vb  [N];
  int ncmp  = 0;
  int nfail = 0;
  int exp_fault_err;
  int first_bad;

  always #5 clk_tb = ~clk_tb;

  alu_bist_ctrl #(.NUM_RAND(NR), .ALU_LATENCY(1)) dut0 (
    .clk(clk_tb), .reset(rst), .start(start),
    .alu_opcode(op0), .alu_a(a0), .alu_b(b0), .alu_vld(vld0), .alu_c(c0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0)
`ifdef BIST_FAIL_LOG_EN
    , .fail_vld(fv0), .fail_opcode(fop0), .fail_a(fa0), .fail_b(fb0),
    .fail_got(fg0), .fail_exp(fe0)
`endif
  );

  alu_bist_ctrl #(.NUM_RAND(NR), .ALU_LATENCY(3)) dut1 (
    .clk(clk_tb), .reset(rst), .start(start),
    .alu_opcode(op1), .alu_a(a1), .alu_b(b1), .alu_vld(vld1), .alu_c(c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef BIST_FAIL_LOG_EN
    , .fail_vld(fv1), .fail_opcode(fop1), .fail_a(fa1), .fail_b(fb1),
    .fail_got(fg1), .fail_exp(fe1)
`endif
  );

  // Behavioural ALU arithmetic on plain integers
  function automatic logic [4:0] ref_alu(input logic [1:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      2'd0:    r = sa + sb;
      2'd1:    r = sa - sb;
      2'd2:    r = 15 - int'(a);
      default: r = (b != 4'd0) ? 1 : 0;
    endcase
    return r[4:0];
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // ALU for dut0 (1 cycle, optional fault: add with A==B returns 0); ALU for dut1 (3 cycles)
  always @(posedge clk_tb) begin
    c0 <= (fault && op0 == 2'd0 && a0 == b0) ? 5'd0 : ref_alu(op0, a0, b0);
    s1 <= ref_alu(op1, a1, b1);
    s2 <= s1;
    c1 <= s2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_0"}, {8'(op0), a0, b0, vld0, busy0, done0, pass0, err0}, 0);
    chk({tag, "_1"}, {8'(op1), a1, b1, vld1, busy1, done1, pass1, err1}, 0);
  endtask

  // One run: start at E0, check every vector, then done/busy timing and final status
  task automatic run(input int abort_at, input int ign_at, input int exp_err0);
    @(negedge clk_tb);
    start = 1'b1;
    @(posedge clk_tb);
    #1;
    start = 1'b0;
    chk("done_clr0", done0, 0);
    chk("err_clr0", err0, 0);
`ifdef BIST_FAIL_LOG_EN
    chk("fvld_clr0", fv0, 0);
`endif
    for (int i = 0; i < N; i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        chk_all_zero("abort");
        @(negedge clk_tb);
        rst = 1'b0;
        return;
      end
      chk("vec0", {op0, a0, b0}, {vop[i], va[i], vb[i]});
      chk("vec1", {op1, a1, b1}, {vop[i], va[i], vb[i]});
      chk("run_flags", {vld0, busy0, vld1, busy1, done0, done1}, 6'b111100);
      if (i == ign_at) start = 1'b1;
      if (i == ign_at + 1) start = 1'b0;
      @(posedge clk_tb);
      #1;
    end
    start = 1'b0;
    for (int c = N; c <= N + 3; c++) begin
      chk("drain_vld", {vld0, vld1}, 0);
      chk("drain_hold", {op0, a0, b0}, {vop[N-1], va[N-1], vb[N-1]});
      chk("done0_t", {done0, busy0}, {c >= N + 1, c < N + 1});
      chk("done1_t", {done1, busy1}, {c >= N + 3, c < N + 3});
      if (c < N + 3) begin
        @(posedge clk_tb);
        #1;
      end
    end
    chk("err0", err0, exp_err0);
    chk("pass0", pass0, exp_err0 == 0);
    chk("err1", err1, 0);
    chk("pass1", pass1, 1);
  endtask

  initial begin
    logic [15:0] lf;
    logic [3:0]  ev [3];
    int k;
    ev = '{4'h0, 4'h8, 4'h7};
    k  = 0;
    for (int op = 0; op < 4; op++)
      for (int ia = 0; ia < 3; ia++)
        for (int ib = 0; ib < 3; ib++) begin
          vop[k] = 2'(op);
          va[k]  = ev[ia];
          vb[k]  = ev[ib];
          k++;
        end
    lf = 16'hACE1;
    for (int j = 0; j < NR; j++) begin
      va[36+j]  = lf[9:6];
      vb[36+j]  = lf[5:2];
      vop[36+j] = lf[1:0];
      lf = lfsr_step(lf);
    end
    exp_fault_err = 0;
    first_bad     = -1;
    for (int i = 0; i < N; i++)
      if (vop[i] == 2'd0 && va[i] == vb[i] && ref_alu(vop[i], va[i], vb[i]) != 5'd0) begin
        exp_fault_err++;
        if (first_bad < 0) first_bad = i;
      end

    rst   = 1'b1;
    start = 1'b0;
    fault = 1'b0;
    repeat (3) @(posedge clk_tb);
    #1;
    chk_all_zero("reset");
    @(negedge clk_tb);
    rst = 1'b0;
    repeat ($urandom_range(1, 4)) @(posedge clk_tb);

    // Faulty ALU on dut0
    fault = 1'b1;
    run(-1, $urandom_range(1, N - 2), exp_fault_err);
`ifdef BIST_FAIL_LOG_EN
    chk("fail_vld0", fv0, 1);
    chk("fail_vec0", {fop0, fa0, fb0}, {vop[first_bad], va[first_bad], vb[first_bad]});
    chk("fail_got0", fg0, 0);
    chk("fail_exp0", fe0, ref_alu(vop[first_bad], va[first_bad], vb[first_bad]));
    chk("fail_vld1", fv1, 0);
`endif

    // Restart from DONE with a correct ALU
    fault = 1'b0;
    run(-1, 5, 0);

    // Mid-run reset, then a clean rerun from vector 0
    run(20, 5, 0);
    repeat ($urandom_range(1, 3)) @(posedge clk_tb);
    #1;
    chk_all_zero("post_abort");
    run(-1, $urandom_range(1, N - 2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/alu_bist_ctrl.md
Name: alu_bist_ctrl

Overview:
Hardware self-test initiator for the 4-bit ALU (ALU_4_bit). It drives Opcode/A/B into the ALU and captures C after a known latency. It compares each result against an internal golden model and counts mismatches. The vector sequence is a fixed edge-value sweep followed by LFSR-random vectors. Sits beside the ALU instance; shares its clock and reset.

Parameters:
NUM_RAND, 50, number of random vectors after the edge sweep (1..1023)
ALU_LATENCY, 1, posedges from ALU sampling A/B/Opcode to C being valid (1..4)
LFSR_SEED, 16'hACE1, LFSR seed; a value of 0 is replaced by 16'h0001
ERR_W, 8, error-counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle run request
alu_opcode  out  2  opcode to the ALU
alu_a  out  4  signed operand A to the ALU
alu_b  out  4  signed operand B to the ALU
alu_vld  out  1  high while a vector is being driven
alu_c  in  5  signed ALU result
busy  out  1  run in progress
done  out  1  run complete; held until the next start
pass  out  1  done and err_count==0
err_count  out  ERR_W  saturating mismatch count

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-high. Reset forces state IDLE. All outputs go to 0 and the LFSR loads the seed. Reset asserted mid-run aborts immediately, with no partial result.
- All outputs are registered.
- States: IDLE -> EDGE -> RAND -> DRAIN -> DONE.
  - IDLE: start=1 at edge E0 loads vector 0, sets busy and alu_vld, clears err_count/done/pass, and reloads the LFSR. Next state is EDGE.
  - EDGE: 36 vectors, one per cycle. Loop order is opcode (0..3, outermost), then A index, then B index (innermost). Edge values are {0, -8 (4'b1000), 7 (4'b0111)}. After vector 35, go to RAND.
  - RAND: NUM_RAND vectors. Each vector is {a,b,opcode} = lfsr[9:0]. The LFSR is 16-bit Galois, taps x^16+x^14+x^13+x^11+1, and advances once per random vector.
  - DRAIN: alu_vld=0, and the outputs hold the last vector. The state persists until the pipeline of pending compares is empty.
  - DONE: busy=0, done=1, pass=(err_count==0). start restarts the run exactly as from IDLE.
- start while busy is ignored.
- Vector i is on the ports after edge E0+i. It is compared at edge E0+i+ALU_LATENCY+1 against an expected value delayed through a shift pipe of depth ALU_LATENCY+1.
- Total vectors N=36+NUM_RAND. done rises at edge E0+N+ALU_LATENCY; for the defaults this is E0+87.
- Golden model, all 5-bit signed:
  - op 00: sext(A)+sext(B)
  - op 01: sext(A)-sext(B)
  - op 10: {1'b0,~A}
  - op 11: {4'b0,|B}
- Comparison uses case-inequality (!==), so X or Z on alu_c counts as a mismatch.
- err_count increments by 1 per mismatch and saturates at 2^ERR_W-1.

Optional Feature:
Macro BIST_FAIL_LOG_EN.
- Defined: adds outputs fail_vld (1), fail_opcode (2), fail_a (4), fail_b (4), fail_got (5), fail_exp (5). They capture the first mismatch of a run, and fail_vld sets at that compare edge. They clear on reset and on start, and later mismatches do not overwrite them.
- Undefined: these ports and registers are absent. All other behaviour is identical.

Decomposition:
- Package alu_bist_pkg:
  - opcode enum (OP_ADD=0, OP_SUB=1, OP_INV_A=2, OP_ROR_B=3)
  - state enum
  - EDGE_VALS[3] constant
  - NUM_EDGE_VEC=36
  - function alu_golden(op,a,b) returning 5-bit
- Sub-module alu_bist_lfsr16 (seed load, advance enable, 16-bit state out).

Test Plan:
- Correct ALU model, defaults, start pulse -> 86 vectors issued; done=1 at E0+87; err_count=0; pass=1; busy high E0..E0+86.
- Faulty ALU forcing add result to 0: A=-8,B=-8 (exp 5'b10000) and A=7,B=7 (exp 5'b01110) mismatch -> err_count>=2; pass=0. With BIST_FAIL_LOG_EN: fail_opcode=0, fail_a=4'b1000, fail_b=4'b1000, fail_got=0, fail_exp=5'b10000.
- Edge checks through the correct model -> sub A=-8,B=7 expects 5'b10001; invert A=7 expects 5'b01000; ROR B=0 expects 5'b00000; all pass.
- Reset asserted at E0+20 mid-run -> all outputs 0 asynchronously; a later start reruns from vector 0 with the identical LFSR sequence.
- start pulsed at E0+5 while busy -> ignored, done still at E0+87. start in DONE -> done falls, err_count clears, full rerun.
- ALU_LATENCY=3 with a 3-cycle ALU model -> err_count=0; done at E0+89.
